// File: rtl/hci_ext_burst_bridge.sv
// Burst-to-word bridge for the HCI external TCDM port: one request per word, read or write.
// Latency: first request the cycle after descriptor accept; read data the cycle after grant at the earliest.
// Backpressure: writes stall on wdata_valid_i/gnt; reads stop issuing once RESP_DEPTH credits are in use.
// Optional perf counters: define HCI_EXT_BRIDGE_PERF_EN.
module hci_ext_burst_bridge #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [AW-1:0]     desc_addr_i,
  input  logic [LEN_W-1:0]  desc_len_i,
  input  logic              desc_wen_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   wdata_be_i,
  output logic              rdata_valid_o,
  input  logic              rdata_ready_i,
  output logic [DW-1:0]     rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [AW-1:0]     tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [DW-1:0]     tcdm_data_o,
  output logic [DW/8-1:0]   tcdm_be_o,
  input  logic [DW-1:0]     tcdm_r_data_i,
  input  logic              tcdm_r_valid_i,
  output logic              tcdm_r_ready_o,
  output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_beats_o
);

  localparam int unsigned   BW      = DW / 8;
  localparam int unsigned   CW      = $clog2(RESP_DEPTH + 1);
  localparam int unsigned   PW      = $clog2(RESP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
  localparam logic [AW-1:0] STEP_C  = AW'(BW);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              wen_q, wen_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DW-1:0]     hold_dat_q, hold_dat_d;
  logic [BW-1:0]     hold_be_q, hold_be_d;
  logic [CW-1:0]     inflight_q, inflight_d;

  logic [DW-1:0]     fifo_mem_q [RESP_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     fifo_cnt_q;

  logic desc_acc, credit_ok, rd_req, wr_req, beat, last_beat, resp_push, fifo_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A new read may only be issued while in-flight reads plus buffered data leave FIFO room.
  assign credit_ok = (inflight_q + fifo_cnt_q) < DEPTH_C;
  assign desc_acc  = (state_q == S_IDLE) && desc_valid_i && !clear_i;
  assign rd_req    = (state_q == S_RD) && credit_ok;
  // Once a write beat is captured it keeps the request up even if the stream drops valid.
  assign wr_req    = (state_q == S_WR) && (hold_vld_q || wdata_valid_i);
  assign beat      = (rd_req || wr_req) && tcdm_gnt_i;
  assign last_beat = beat && (rem_q == LEN_W'(1));
  // Responses are only accepted for reads actually outstanding in this burst.
  assign resp_push = tcdm_r_valid_i && ((state_q == S_RD) || (state_q == S_DRAIN))
                     && (inflight_q != '0);
  assign fifo_pop  = (fifo_cnt_q != '0) && rdata_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear_i overrides every other event
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (desc_valid_i) state_d = (desc_len_i == '0) ? S_DONE :
                                             (desc_wen_i ? S_RD : S_WR);
        S_RD:    if (last_beat) state_d = S_DRAIN;
        S_WR:    if (last_beat) state_d = S_DONE;
        S_DRAIN: if ((inflight_q == '0) || ((inflight_q == CW'(1)) && resp_push))
                   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state and the request qualifiers
  always_comb begin
    desc_ready_o  = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    tcdm_req_o    = 1'b0;
    tcdm_data_o   = '0;
    tcdm_be_o     = '0;
    wdata_ready_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        desc_ready_o = !clear_i;
        busy_o       = 1'b0;
      end
      S_RD:   tcdm_req_o = rd_req;
      S_WR: begin
        tcdm_req_o    = wr_req;
        tcdm_data_o   = hold_vld_q ? hold_dat_q : wdata_i;
        tcdm_be_o     = hold_vld_q ? hold_be_q  : wdata_be_i;
        wdata_ready_o = wr_req && tcdm_gnt_i;
      end
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  assign tcdm_add_o     = addr_q;
  assign tcdm_wen_o     = wen_q;
  assign tcdm_r_ready_o = 1'b1;

  // Burst bookkeeping: address/length walk, write-beat skid, in-flight read count
  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    wen_d      = wen_q;
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    hold_be_d  = hold_be_q;
    inflight_d = inflight_q;
    if (clear_i) begin
      hold_vld_d = 1'b0;
      inflight_d = '0;
    end else begin
      if (desc_acc) begin
        addr_d = desc_addr_i;
        rem_d  = desc_len_i;
        wen_d  = desc_wen_i;
      end else if (beat) begin
        addr_d = addr_q + STEP_C;
        rem_d  = rem_q - LEN_W'(1);
      end
      if (wr_req && tcdm_gnt_i) begin
        hold_vld_d = 1'b0;
      end else if (wr_req && !hold_vld_q) begin
        hold_vld_d = 1'b1;
        hold_dat_d = wdata_i;
        hold_be_d  = wdata_be_i;
      end
      inflight_d = inflight_q + ((rd_req && tcdm_gnt_i) ? CW'(1) : '0)
                              - (resp_push ? CW'(1) : '0);
    end
  end

  // Bookkeeping registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      rem_q      <= '0;
      wen_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      hold_be_q  <= '0;
      inflight_q <= '0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wen_q      <= wen_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      hold_be_q  <= hold_be_d;
      inflight_q <= inflight_d;
    end
  end

  // Response FIFO pointers and occupancy; simultaneous push/pop leaves the count unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else if (clear_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (resp_push) wptr_q <= ptr_inc(wptr_q);
      if (fifo_pop)  rptr_q <= ptr_inc(rptr_q);
      fifo_cnt_q <= fifo_cnt_q + (resp_push ? CW'(1) : '0) - (fifo_pop ? CW'(1) : '0);
    end
  end

  // Response FIFO storage (no reset needed: read out only when occupied)
  always_ff @(posedge clk_i) begin
    if (resp_push) fifo_mem_q[wptr_q] <= tcdm_r_data_i;
  end

  assign rdata_valid_o = (fifo_cnt_q != '0);
  assign rdata_o       = rdata_valid_o ? fifo_mem_q[rptr_q] : '0;

`ifdef HCI_EXT_BRIDGE_PERF_EN
  logic [PERF_W-1:0] stall_q, beats_q;

  // Saturating stall/beat counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      beats_q <= '0;
    end else if (clear_i) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if ((rd_req || wr_req) && !tcdm_gnt_i && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
      if (beat && (beats_q != '1)) beats_q <= beats_q + PERF_W'(1);
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_beats_o = beats_q;
`else
  assign perf_stall_o = '0;
  assign perf_beats_o = '0;
`endif

endmodule

// File: tb/tb_hci_ext_burst_bridge.sv
// Self-checking bench for hci_ext_burst_bridge: vector table plus directed multi-cycle sequences.
// A small TCDM model answers each granted read the next cycle with a known address pattern.
// Expected perf counter values follow HCI_EXT_BRIDGE_PERF_EN.
module tb_hci_ext_burst_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_addr = '0;
  logic [15:0] desc_len = '0;
  logic        desc_wen = 1'b0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic [3:0]  wdata_be = '0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        busy, done;
  logic        tcdm_req;
  logic        gnt = 1'b0;
  logic [31:0] tcdm_add;
  logic        tcdm_wen;
  logic [31:0] tcdm_data;
  logic [3:0]  tcdm_be;
  logic [31:0] mdl_rdata;
  logic        mdl_rvalid;
  logic        spur_rvalid = 1'b0;
  logic        tcdm_r_ready;
  logic [31:0] perf_stall, perf_beats;

  int checks = 0;
  int failures = 0;
  int grant_cnt = 0;
  logic [31:0] glog [64];

  always #5 clk = ~clk;

  hci_ext_burst_bridge dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .desc_addr_i(desc_addr), .desc_len_i(desc_len), .desc_wen_i(desc_wen),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .wdata_i(wdata), .wdata_be_i(wdata_be),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
    .busy_o(busy), .done_o(done),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(gnt), .tcdm_add_o(tcdm_add),
    .tcdm_wen_o(tcdm_wen), .tcdm_data_o(tcdm_data), .tcdm_be_o(tcdm_be),
    .tcdm_r_data_i(mdl_rdata), .tcdm_r_valid_i(mdl_rvalid | spur_rvalid),
    .tcdm_r_ready_o(tcdm_r_ready),
    .perf_stall_o(perf_stall), .perf_beats_o(perf_beats)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // TCDM model: in-order read responses one cycle after grant; logs granted addresses
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_rvalid <= 1'b0;
      mdl_rdata  <= '0;
    end else begin
      mdl_rvalid <= tcdm_req && gnt && tcdm_wen;
      mdl_rdata  <= mem_f(tcdm_add);
      if (tcdm_req && gnt) begin
        glog[grant_cnt % 64] <= tcdm_add;
        grant_cnt <= grant_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        dv;
    logic [15:0] len;
    logic [31:0] addr;
    logic        wv;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        e_req;
    logic [31:0] e_add;
    logic [31:0] e_dat;
    logic [3:0]  e_be;
    logic        e_wrdy;
    logic        e_busy;
    logic        e_done;
    logic        e_drdy;
  } vec_t;

  function automatic vec_t mk(input logic dv, input logic [15:0] len, input logic [31:0] addr,
                              input logic wv, input logic [31:0] wd, input logic [3:0] be,
                              input logic e_req, input logic [31:0] e_add, input logic [31:0] e_dat,
                              input logic [3:0] e_be, input logic e_wrdy, input logic e_busy,
                              input logic e_done, input logic e_drdy);
    vec_t v;
    v.dv = dv; v.len = len; v.addr = addr; v.wv = wv; v.wd = wd; v.be = be;
    v.e_req = e_req; v.e_add = e_add; v.e_dat = e_dat; v.e_be = e_be;
    v.e_wrdy = e_wrdy; v.e_busy = e_busy; v.e_done = e_done; v.e_drdy = e_drdy;
    return v;
  endfunction

  task automatic send_desc(input logic [31:0] a, input logic [15:0] l, input logic w);
    desc_valid = 1'b1; desc_addr = a; desc_len = l; desc_wen = w;
    @(negedge clk);
    chk("desc_ready", 64'(desc_ready), 64'd1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic collect(input logic [31:0] base, input int n, input int budget);
    int got;
    int dones;
    logic [31:0] a;
    got = 0; dones = 0;
    rdata_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (rdata_valid) begin
        a = base + 32'(4 * got);
        chk($sformatf("rdata%0d", got), 64'(rdata), 64'(mem_f(a)));
        got++;
      end
      @(posedge clk); #1;
      if (got == n && dones > 0) break;
    end
    rdata_ready = 1'b0;
    chk("rd_beats", 64'(got), 64'(n));
    chk("rd_done_pulses", 64'(dones), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    int   base;
    logic [31:0] exp_stall, exp_beats;

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.desc_ready", 64'(desc_ready), 64'd1);
    chk("rst.r_ready", 64'(tcdm_r_ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.req", 64'(tcdm_req), 64'd0);
    chk("rst.add", 64'(tcdm_add), 64'd0);
    chk("rst.wen", 64'(tcdm_wen), 64'd0);
    chk("rst.data", 64'(tcdm_data), 64'd0);
    chk("rst.be", 64'(tcdm_be), 64'd0);
    chk("rst.wready", 64'(wdata_ready), 64'd0);
    chk("rst.rvalid", 64'(rdata_valid), 64'd0);
    chk("rst.rdata", 64'(rdata), 64'd0);
    chk("rst.perf_stall", 64'(perf_stall), 64'd0);
    chk("rst.perf_beats", 64'(perf_beats), 64'd0);
    @(posedge clk); #1;

    // ---- r_valid while idle must be discarded
    spur_rvalid = 1'b1;
    @(posedge clk); #1;
    spur_rvalid = 1'b0;
    @(negedge clk);
    chk("spur.rvalid", 64'(rdata_valid), 64'd0);
    @(posedge clk); #1;

    // ---- vector table: write len=4 @0x100, len=0 descriptor, write stalled by wdata_valid
    tbl[0]  = mk(1, 4, 32'h100, 1, 32'hD000_0000, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 1, 32'hD000_0000, 4'hF, 1, 32'h100, 32'hD000_0000, 4'hF, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 32'hD000_0001, 4'hF, 1, 32'h104, 32'hD000_0001, 4'hF, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 32'hD000_0002, 4'hF, 1, 32'h108, 32'hD000_0002, 4'hF, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 32'hD000_0003, 4'hF, 1, 32'h10C, 32'hD000_0003, 4'hF, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 32'hE000_0000, 4'h3, 1, 32'h200, 32'hE000_0000, 4'h3, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    gnt = 1'b1;
    for (int i = 0; i < 15; i++) begin
      desc_valid = tbl[i].dv; desc_len = tbl[i].len; desc_addr = tbl[i].addr; desc_wen = 1'b0;
      wdata_valid = tbl[i].wv; wdata = tbl[i].wd; wdata_be = tbl[i].be;
      @(negedge clk);
      chk($sformatf("v%0d.req", i), 64'(tcdm_req), 64'(tbl[i].e_req));
      chk($sformatf("v%0d.wready", i), 64'(wdata_ready), 64'(tbl[i].e_wrdy));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("v%0d.done", i), 64'(done), 64'(tbl[i].e_done));
      chk($sformatf("v%0d.desc_ready", i), 64'(desc_ready), 64'(tbl[i].e_drdy));
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d.add", i), 64'(tcdm_add), 64'(tbl[i].e_add));
        chk($sformatf("v%0d.data", i), 64'(tcdm_data), 64'(tbl[i].e_dat));
        chk($sformatf("v%0d.be", i), 64'(tcdm_be), 64'(tbl[i].e_be));
        chk($sformatf("v%0d.wen", i), 64'(tcdm_wen), 64'd0);
      end
      @(posedge clk); #1;
    end
    desc_valid = 1'b0; wdata_valid = 1'b0;

    // ---- write len=3 @0x300, grant withheld 3 cycles on the second beat
    wdata_valid = 1'b1; wdata = 32'hA000_0000; wdata_be = 4'hF; gnt = 1'b1;
    send_desc(32'h300, 16'd3, 1'b0);
    @(negedge clk);
    chk("st.b0.add", 64'(tcdm_add), 64'h300);
    @(posedge clk); #1;
    wdata = 32'hA000_0001; wdata_be = 4'h5; gnt = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin wdata = 32'hBAD0_BAD0; wdata_be = 4'hA; end
      if (s == 2) wdata_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("st%0d.req", s), 64'(tcdm_req), 64'd1);
      chk($sformatf("st%0d.add", s), 64'(tcdm_add), 64'h304);
      chk($sformatf("st%0d.data", s), 64'(tcdm_data), 64'hA000_0001);
      chk($sformatf("st%0d.be", s), 64'(tcdm_be), 64'h5);
      chk($sformatf("st%0d.wready", s), 64'(wdata_ready), 64'd0);
      @(posedge clk); #1;
    end
    wdata_valid = 1'b1; wdata = 32'hA000_0001; wdata_be = 4'h5; gnt = 1'b1;
    @(negedge clk);
    chk("st.b1.data", 64'(tcdm_data), 64'hA000_0001);
    chk("st.b1.wready", 64'(wdata_ready), 64'd1);
    @(posedge clk); #1;
    wdata = 32'hA000_0002; wdata_be = 4'hF;
    @(negedge clk);
    chk("st.b2.add", 64'(tcdm_add), 64'h308);
    chk("st.b2.data", 64'(tcdm_data), 64'hA000_0002);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("st.done", 64'(done), 64'd1);
`ifdef HCI_EXT_BRIDGE_PERF_EN
    exp_stall = 32'd3; exp_beats = 32'd8;
`else
    exp_stall = 32'd0; exp_beats = 32'd0;
`endif
    chk("st.perf_stall", 64'(perf_stall), 64'(exp_stall));
    chk("st.perf_beats", 64'(perf_beats), 64'(exp_beats));
    @(posedge clk); #1;

    // ---- read len=8 with the consumer stalled: only RESP_DEPTH grants
    gnt = 1'b1; rdata_ready = 1'b0;
    base = grant_cnt;
    send_desc(32'h1000, 16'd8, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rd8.grants_stalled", 64'(grant_cnt - base), 64'd4);
    chk("rd8.req_low", 64'(tcdm_req), 64'd0);
    chk("rd8.busy", 64'(busy), 64'd1);
    chk("rd8.rvalid", 64'(rdata_valid), 64'd1);
    @(posedge clk); #1;
    collect(32'h1000, 8, 80);
    chk("rd8.grants_total", 64'(grant_cnt - base), 64'd8);

    // ---- read len=2 across the top of the address space
    base = grant_cnt;
    send_desc(32'hFFFF_FFFC, 16'd2, 1'b1);
    collect(32'hFFFF_FFFC, 2, 40);
    chk("wrap.add0", 64'(glog[base % 64]), 64'hFFFF_FFFC);
    chk("wrap.add1", 64'(glog[(base + 1) % 64]), 64'h0);

    // ---- clear during a stalled write, then a normal read burst
    gnt = 1'b0; wdata_valid = 1'b1; wdata = 32'hC000_0000; wdata_be = 4'hF;
    send_desc(32'h400, 16'd2, 1'b0);
    @(negedge clk);
    chk("clr.req_before", 64'(tcdm_req), 64'd1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    chk("clr.done_during", 64'(done), 64'd0);
    @(posedge clk); #1;
    clear = 1'b0; wdata_valid = 1'b0;
    @(negedge clk);
    chk("clr.req", 64'(tcdm_req), 64'd0);
    chk("clr.busy", 64'(busy), 64'd0);
    chk("clr.desc_ready", 64'(desc_ready), 64'd1);
    chk("clr.done", 64'(done), 64'd0);
    chk("clr.perf_stall", 64'(perf_stall), 64'd0);
    chk("clr.perf_beats", 64'(perf_beats), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr.done_after", 64'(done), 64'd0);
    @(posedge clk); #1;
    gnt = 1'b1;
    send_desc(32'h500, 16'd3, 1'b1);
    collect(32'h500, 3, 40);

    // ---- asynchronous reset in the middle of a write burst
    gnt = 1'b0; wdata_valid = 1'b1; wdata = 32'hF000_0000;
    send_desc(32'h600, 16'd2, 1'b0);
    @(negedge clk);
    chk("arst.req_before", 64'(tcdm_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.req", 64'(tcdm_req), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.desc_ready", 64'(desc_ready), 64'd1);
    chk("arst.add", 64'(tcdm_add), 64'd0);
    wdata_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
